// File: rtl/rocketcpu_audio_pkg.sv
// Shared definitions for the audio register bus arbiter: FSM state
// encoding, audio register map bases and the default slave timeout.
package rocketcpu_audio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY0   = 2'd1,
    BUSY1   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam logic [31:0] AUDIO_REG_BASE   = 32'h1000_0000;
  localparam logic [31:0] INPUT_PARAM_BASE = 32'h1001_0000;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  // Last-grant value after reset: pointing at master 1 makes master 0 win
  // the first tie.
  localparam logic RR_LAST_RESET = 1'b1;

endpackage

// File: rtl/rocketcpu_rr_arbiter2.sv
// Two-way round-robin picker with its last-grant register. The pick is
// combinational; last only moves when a grant is actually issued.
module rocketcpu_rr_arbiter2
  import rocketcpu_audio_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic en,
  output logic gnt0,
  output logic gnt1
);

  logic last;

  // Pick a winner; on a tie the master that was not granted last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        if (last) gnt0 = 1'b1;
        else      gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Remember which master received the most recent grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last <= RR_LAST_RESET;
    else if (gnt0) last <= 1'b0;
    else if (gnt1) last <= 1'b1;
  end

endmodule

// File: rtl/rocketcpu_audio_wb_arbiter.sv
// Two-master / one-slave Wishbone arbiter in front of the audio parameter
// register slave. One transaction per grant, round-robin between masters,
// and a forced idle cycle on the slave bus after every transaction because
// the slave derives its ack from cyc.
// Optional macro ROCKETCPU_AUDIO_ARB_TIMEOUT_EN adds a per-transaction
// watchdog that completes a hung access with zero data and raises the
// sticky o_timeout flag.
module rocketcpu_audio_wb_arbiter
  import rocketcpu_audio_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TO_W           = 7
) (
  input  logic        i_wb_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_m0_adr,
  input  logic [31:0] i_m0_dat,
  input  logic [3:0]  i_m0_sel,
  input  logic        i_m0_we,
  input  logic        i_m0_cyc,
  output logic [31:0] o_m0_rdt,
  output logic        o_m0_ack,
  input  logic [31:0] i_m1_adr,
  input  logic [31:0] i_m1_dat,
  input  logic [3:0]  i_m1_sel,
  input  logic        i_m1_we,
  input  logic        i_m1_cyc,
  output logic [31:0] o_m1_rdt,
  output logic        o_m1_ack,
  output logic [31:0] o_s_adr,
  output logic [31:0] o_s_dat,
  output logic [3:0]  o_s_sel,
  output logic        o_s_we,
  output logic        o_s_cyc,
  input  logic [31:0] i_s_rdt,
  input  logic        i_s_ack,
  output logic        o_timeout
);

  // The timeout counter must be able to hold TIMEOUT_CYCLES-1.
  if (TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_to_w_check
    $error("TO_W is too narrow for TIMEOUT_CYCLES");
  end

  arb_state_t state;
  arb_state_t state_nxt;
  logic       arb_en;
  logic       gnt0;
  logic       gnt1;
  logic       to_fire;

  assign arb_en = (state == IDLE);

  rocketcpu_rr_arbiter2 u_rr (
    .clk   (i_wb_clk),
    .rst_n (i_rst_n),
    .req0  (i_m0_cyc),
    .req1  (i_m1_cyc),
    .en    (arb_en),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

`ifdef ROCKETCPU_AUDIO_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            to_flag;
  logic            busy;
  logic            cur_cyc;

  assign busy    = (state == BUSY0) || (state == BUSY1);
  assign cur_cyc = (state == BUSY1) ? i_m1_cyc : i_m0_cyc;
  // A real slave ack in the expiry cycle takes precedence over the timeout.
  assign to_fire = busy && cur_cyc && !i_s_ack &&
                   (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in a busy state; zero outside so each grant starts fresh.
  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n)  to_cnt <= '0;
    else if (busy) to_cnt <= to_cnt + TO_W'(1);
    else           to_cnt <= '0;
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n)     to_flag <= 1'b0;
    else if (to_fire) to_flag <= 1'b1;
  end

  assign o_timeout = to_flag;
`else
  assign to_fire   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // FSM state register; reset drops the slave bus immediately.
  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state plus the bus mux: only the granted master reaches the slave
  // and only it sees ack/rdt; acks are qualified by the master's own cyc.
  always_comb begin
    state_nxt = state;
    o_s_adr   = '0;
    o_s_dat   = '0;
    o_s_sel   = '0;
    o_s_we    = 1'b0;
    o_s_cyc   = 1'b0;
    o_m0_rdt  = '0;
    o_m0_ack  = 1'b0;
    o_m1_rdt  = '0;
    o_m1_ack  = 1'b0;
    case (state)
      IDLE: begin
        if (gnt0)      state_nxt = BUSY0;
        else if (gnt1) state_nxt = BUSY1;
      end
      BUSY0: begin
        o_s_cyc  = 1'b1;
        o_s_adr  = i_m0_adr;
        o_s_dat  = i_m0_dat;
        o_s_sel  = i_m0_sel;
        o_s_we   = i_m0_we;
        o_m0_rdt = to_fire ? '0 : i_s_rdt;
        o_m0_ack = i_m0_cyc && (i_s_ack || to_fire);
        if (!i_m0_cyc || i_s_ack || to_fire) state_nxt = RELEASE;
      end
      BUSY1: begin
        o_s_cyc  = 1'b1;
        o_s_adr  = i_m1_adr;
        o_s_dat  = i_m1_dat;
        o_s_sel  = i_m1_sel;
        o_s_we   = i_m1_we;
        o_m1_rdt = to_fire ? '0 : i_s_rdt;
        o_m1_ack = i_m1_cyc && (i_s_ack || to_fire);
        if (!i_m1_cyc || i_s_ack || to_fire) state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rocketcpu_audio_wb_arbiter.sv
// Bench for rocketcpu_audio_wb_arbiter: transaction-level model of who owns
// the slave bus, checked every cycle, plus literal expectations per scenario.
module tb_rocketcpu_audio_wb_arbiter;

  localparam int TCYC = 8;
`ifdef ROCKETCPU_AUDIO_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } txn_t;

  typedef struct {
    int          cyc;
    int          m;
    logic [31:0] rdt;
  } ack_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_m0_adr = '0, i_m0_dat = '0, i_m1_adr = '0, i_m1_dat = '0;
  logic [3:0]  i_m0_sel = '0, i_m1_sel = '0;
  logic        i_m0_we = 1'b0, i_m0_cyc = 1'b0, i_m1_we = 1'b0, i_m1_cyc = 1'b0;
  logic [31:0] o_m0_rdt, o_m1_rdt, o_s_adr, o_s_dat, i_s_rdt;
  logic        o_m0_ack, o_m1_ack, o_s_we, o_s_cyc, i_s_ack, o_timeout;
  logic [3:0]  o_s_sel;

  // Behavioural slave: acks after s_lat cycles of cyc; -1 never acks.
  int          s_lat = 2;
  int          s_cnt = 0;
  logic [31:0] s_data = '0;
  logic        stray_ack = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_s_cyc) s_cnt <= s_cnt + 1;
    else         s_cnt <= 0;
  end

  assign i_s_ack = (o_s_cyc && (s_cnt == s_lat)) || stray_ack;
  assign i_s_rdt = s_data;

  rocketcpu_audio_wb_arbiter #(.TIMEOUT_CYCLES(TCYC), .TO_W(4)) dut (
    .i_wb_clk (clk),      .i_rst_n  (rst_n),
    .i_m0_adr (i_m0_adr), .i_m0_dat (i_m0_dat), .i_m0_sel (i_m0_sel),
    .i_m0_we  (i_m0_we),  .i_m0_cyc (i_m0_cyc), .o_m0_rdt (o_m0_rdt),
    .o_m0_ack (o_m0_ack),
    .i_m1_adr (i_m1_adr), .i_m1_dat (i_m1_dat), .i_m1_sel (i_m1_sel),
    .i_m1_we  (i_m1_we),  .i_m1_cyc (i_m1_cyc), .o_m1_rdt (o_m1_rdt),
    .o_m1_ack (o_m1_ack),
    .o_s_adr  (o_s_adr),  .o_s_dat  (o_s_dat),  .o_s_sel  (o_s_sel),
    .o_s_we   (o_s_we),   .o_s_cyc  (o_s_cyc),  .i_s_rdt  (i_s_rdt),
    .i_s_ack  (i_s_ack),  .o_timeout(o_timeout)
  );

  // Model: owner of the bus (-1 none), pending release gap, last winner.
  int   m_owner = -1;
  logic m_rel = 1'b0;
  int   m_last = 1;
  int   m_cnt = 0;
  logic m_to = 1'b0;
  logic sv_c0 = 1'b0, sv_c1 = 1'b0, sv_ack = 1'b0, sv_fire = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1; m_rel <= 1'b0; m_last <= 1; m_cnt <= 0; m_to <= 1'b0;
    end else if (m_rel) begin
      m_rel <= 1'b0;
    end else if (m_owner < 0) begin
      if (sv_c0 && sv_c1) begin
        m_owner <= (m_last == 1) ? 0 : 1;
        m_last  <= (m_last == 1) ? 0 : 1;
        m_cnt   <= 0;
      end else if (sv_c0) begin
        m_owner <= 0; m_last <= 0; m_cnt <= 0;
      end else if (sv_c1) begin
        m_owner <= 1; m_last <= 1; m_cnt <= 0;
      end
    end else begin
      if (!((m_owner == 1) ? sv_c1 : sv_c0) || sv_ack || sv_fire) begin
        m_owner <= -1;
        m_rel   <= 1'b1;
        if (sv_fire) m_to <= 1'b1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc_no = 0;
  logic [31:0] trace = '0;
  logic        auto_drv = 1'b1;
  txn_t        q0[$];
  txn_t        q1[$];
  ack_t        alog[$];
  wr_t         wlog[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_no);
    end
  endtask

  task automatic compare_model(output logic fire);
    logic [31:0] e_adr, e_dat, e_r0, e_r1;
    logic [3:0]  e_sel;
    logic        e_we, e_cyc, e_a0, e_a1, cn;
    e_adr = '0; e_dat = '0; e_r0 = '0; e_r1 = '0; e_sel = '0;
    e_we = 1'b0; e_cyc = 1'b0; e_a0 = 1'b0; e_a1 = 1'b0; cn = 1'b0; fire = 1'b0;
    if (!m_rel && m_owner >= 0) begin
      cn    = (m_owner == 1) ? i_m1_cyc : i_m0_cyc;
      fire  = TO_EN && cn && !i_s_ack && (m_cnt == TCYC - 1);
      e_cyc = 1'b1;
      e_adr = (m_owner == 1) ? i_m1_adr : i_m0_adr;
      e_dat = (m_owner == 1) ? i_m1_dat : i_m0_dat;
      e_sel = (m_owner == 1) ? i_m1_sel : i_m0_sel;
      e_we  = (m_owner == 1) ? i_m1_we  : i_m0_we;
      if (m_owner == 0) begin
        e_a0 = cn && (i_s_ack || fire);
        e_r0 = fire ? 32'h0 : i_s_rdt;
      end else begin
        e_a1 = cn && (i_s_ack || fire);
        e_r1 = fire ? 32'h0 : i_s_rdt;
      end
    end
    check("s_cyc",   32'(o_s_cyc),   32'(e_cyc));
    check("s_adr",   o_s_adr,        e_adr);
    check("s_dat",   o_s_dat,        e_dat);
    check("s_sel",   32'(o_s_sel),   32'(e_sel));
    check("s_we",    32'(o_s_we),    32'(e_we));
    check("m0_ack",  32'(o_m0_ack),  32'(e_a0));
    check("m0_rdt",  o_m0_rdt,       e_r0);
    check("m1_ack",  32'(o_m1_ack),  32'(e_a1));
    check("m1_rdt",  o_m1_rdt,       e_r1);
    check("timeout", 32'(o_timeout), 32'(m_to));
  endtask

  task automatic load_masters();
    if (q0.size() > 0) begin
      i_m0_cyc = 1'b1; i_m0_adr = q0[0].adr; i_m0_dat = q0[0].dat;
      i_m0_sel = q0[0].sel; i_m0_we = q0[0].we;
    end else begin
      i_m0_cyc = 1'b0; i_m0_adr = '0; i_m0_dat = '0; i_m0_sel = '0; i_m0_we = 1'b0;
    end
    if (q1.size() > 0) begin
      i_m1_cyc = 1'b1; i_m1_adr = q1[0].adr; i_m1_dat = q1[0].dat;
      i_m1_sel = q1[0].sel; i_m1_we = q1[0].we;
    end else begin
      i_m1_cyc = 1'b0; i_m1_adr = '0; i_m1_dat = '0; i_m1_sel = '0; i_m1_we = 1'b0;
    end
  endtask

  // One clock: sample and check at negedge, advance masters after posedge.
  task automatic step();
    logic a0, a1, f;
    @(negedge clk);
    cyc_no++;
    a0 = o_m0_ack;
    a1 = o_m1_ack;
    trace = {trace[30:0], o_s_cyc};
    if (o_m0_ack) alog.push_back('{cyc_no, 0, o_m0_rdt});
    if (o_m1_ack) alog.push_back('{cyc_no, 1, o_m1_rdt});
    if (o_s_cyc && i_s_ack && o_s_we) wlog.push_back({o_s_adr, o_s_dat});
    f = 1'b0;
    if (rst_n) compare_model(f);
    sv_c0 = i_m0_cyc; sv_c1 = i_m1_cyc; sv_ack = i_s_ack; sv_fire = f;
    @(posedge clk);
    #1;
    if (auto_drv) begin
      if (a0 && q0.size() > 0) void'(q0.pop_front());
      if (a1 && q1.size() > 0) void'(q1.pop_front());
      load_masters();
    end
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check(nm, 32'(q0.size() + q1.size()), 32'd0);
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "time limit exceeded");
  end

  initial begin
    int base;
    int t0;

    // Reset with both masters already requesting; m0 must win the first tie.
    s_lat = 1;
    q0.push_back('{32'h1000_0000, 32'hAAAA_0001, 4'hF, 1'b1});
    q1.push_back('{32'h1000_0008, 32'hBBBB_0002, 4'hF, 1'b1});
    load_masters();
    repeat (3) step();
    check("rst_s_cyc",   32'(o_s_cyc),   32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    check("rst_m0_ack",  32'(o_m0_ack),  32'd0);
    check("rst_m1_ack",  32'(o_m1_ack),  32'd0);
    check("rst_s_adr",   o_s_adr,        32'd0);
    rst_n = 1'b1;
    drain("simul_drain", 40);
    check("simul_nwr",   32'(wlog.size()), 32'd2);
    check("simul_wr0",   wlog[0][63:32], 32'h1000_0000);
    check("simul_wd0",   wlog[0][31:0],  32'hAAAA_0001);
    check("simul_wr1",   wlog[1][63:32], 32'h1000_0008);
    check("simul_wd1",   wlog[1][31:0],  32'hBBBB_0002);
    check("simul_first", 32'(alog[0].m), 32'd0);
    check("simul_second", 32'(alog[1].m), 32'd1);

    // Two back-to-back m0 reads, slave acks on the third cycle of cyc.
    s_lat = 2;
    s_data = 32'h0000_1234;
    base = alog.size();
    q0.push_back('{32'h1000_0004, 32'h0, 4'hF, 1'b0});
    q0.push_back('{32'h1000_0004, 32'h0, 4'hF, 1'b0});
    step();
    t0 = cyc_no + 1;
    trace = '0;
    repeat (11) step();
    check("read_trace", trace, 32'b01110011100);
    check("read_nack",  32'(alog.size() - base), 32'd2);
    check("read_rdt",   alog[base].rdt, 32'h0000_1234);
    check("read_lat",   32'(alog[base].cyc - t0), 32'd3);
    check("read_lat2",  32'(alog[base + 1].cyc - t0), 32'd8);
    drain("read_drain", 20);

    // Fairness: six writes each, zero-latency slave; m0 was granted last.
    s_lat = 0;
    base = alog.size();
    for (int i = 0; i < 6; i++) begin
      q0.push_back('{AUDIO_ADR(i), 32'hA000_0000 + 32'(i), 4'hF, 1'b1});
      q1.push_back('{AUDIO_ADR(i + 8), 32'hB000_0000 + 32'(i), 4'h3, 1'b1});
    end
    load_masters();
    drain("fair_drain", 100);
    check("fair_nack", 32'(alog.size() - base), 32'd12);
    for (int k = 0; k < 12; k++)
      check("fair_order", 32'(alog[base + k].m), (k % 2 == 0) ? 32'd1 : 32'd0);

    // Abort: m1 drops cyc in its second busy cycle, stray slave ack follows.
    auto_drv = 1'b0;
    s_lat = -1;
    base = alog.size();
    i_m1_adr = 32'h1001_0010; i_m1_sel = 4'hF; i_m1_we = 1'b0; i_m1_cyc = 1'b1;
    trace = '0;
    step();
    step();
    i_m1_cyc = 1'b0;
    step();
    stray_ack = 1'b1;
    step();
    stray_ack = 1'b0;
    step();
    check("abort_trace", trace, 32'b01100);
    check("abort_noack", 32'(alog.size() - base), 32'd0);
    auto_drv = 1'b1;
    s_lat = 1;
    s_data = 32'h5555_AAAA;
    q0.push_back('{32'h1000_000C, 32'h0, 4'hF, 1'b0});
    load_masters();
    drain("abort_drain", 20);
    check("abort_next_n",   32'(alog.size() - base), 32'd1);
    check("abort_next_m",   32'(alog[base].m), 32'd0);
    check("abort_next_rdt", alog[base].rdt, 32'h5555_AAAA);

    // Hung slave on an m0 read.
    s_lat = -1;
    s_data = 32'hDEAD_BEEF;
    base = alog.size();
    q0.push_back('{32'h1000_0010, 32'h0, 4'hF, 1'b0});
    step();
    t0 = cyc_no + 1;
    if (TO_EN) begin
      for (int n = 0; n < 40 && alog.size() == base; n++) step();
      check("to_nack", 32'(alog.size() - base), 32'd1);
      if (alog.size() > base) begin
        check("to_cycle", 32'(alog[base].cyc - t0), 32'd8);
        check("to_rdt",   alog[base].rdt, 32'h0);
        check("to_m",     32'(alog[base].m), 32'd0);
      end
      repeat (5) step();
      check("to_sticky", 32'(o_timeout), 32'd1);
    end else begin
      repeat (20) step();
      check("hang_noack",   32'(alog.size() - base), 32'd0);
      check("hang_timeout", 32'(o_timeout), 32'd0);
      check("hang_cyc",     32'(o_s_cyc), 32'd1);
      q0.delete();
      load_masters();
      repeat (4) step();
    end

    // Async reset in the middle of an m1 transaction.
    s_lat = -1;
    q1.push_back('{32'h1000_0020, 32'h0, 4'hF, 1'b0});
    step();
    step();
    check("ar_pre_cyc", 32'(o_s_cyc), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_s_cyc",   32'(o_s_cyc),   32'd0);
    check("ar_m1_ack",  32'(o_m1_ack),  32'd0);
    check("ar_timeout", 32'(o_timeout), 32'd0);
    step();
    s_lat = 1;
    s_data = 32'h0BAD_F00D;
    q0.push_back('{32'h1000_0024, 32'h0, 4'hF, 1'b0});
    load_masters();
    base = alog.size();
    rst_n = 1'b1;
    drain("ar_drain", 30);
    check("ar_nack",  32'(alog.size() - base), 32'd2);
    check("ar_first", 32'(alog[base].m), 32'd0);
    check("ar_rdt",   alog[base].rdt, 32'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  function automatic logic [31:0] AUDIO_ADR(input int idx);
    return 32'h1000_0000 + 32'(idx * 4);
  endfunction

endmodule

// File: doc/rocketcpu_audio_wb_arbiter.md
Name: rocketcpu_audio_wb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares the audio parameter register slave between the CPU data port (master 0) and a secondary requester such as a preset loader or debug bridge (master 1).
- Fair round-robin grant; one transaction per grant.
- Enforces a mandatory idle cycle on the slave bus between transactions. The slave derives ack from cyc and must see cyc low before it can ack again.
- Sits between the CPU bus mux and the audio register slave.

Parameters:
- TIMEOUT_CYCLES, 64, slave cycles allowed before forced completion (used only when the optional feature is enabled)
- TO_W, 7, timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYCLES

Ports:
- i_wb_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_m0_adr  in  32  master 0 address
- i_m0_dat  in  32  master 0 write data
- i_m0_sel  in  4  master 0 byte select
- i_m0_we  in  1  master 0 write enable
- i_m0_cyc  in  1  master 0 request
- o_m0_rdt  out  32  master 0 read data
- o_m0_ack  out  1  master 0 ack
- i_m1_adr, i_m1_dat, i_m1_sel, i_m1_we, i_m1_cyc, o_m1_rdt, o_m1_ack: same as master 0, for master 1
- o_s_adr  out  32  slave address
- o_s_dat  out  32  slave write data
- o_s_sel  out  4  slave byte select
- o_s_we  out  1  slave write enable
- o_s_cyc  out  1  slave cycle
- i_s_rdt  in  32  slave read data
- i_s_ack  in  1  slave ack
- o_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - state=IDLE, last=1 (so master 0 wins the first tie), counter=0.
  - o_s_cyc=0, o_timeout=0, both acks 0.
- States: IDLE, BUSY0, BUSY1, RELEASE.
- IDLE:
  - Only m0 cyc asserted -> BUSY0; only m1 -> BUSY1.
  - Both asserted -> the master not equal to last. last is updated on grant.
  - Grant is registered, so o_s_cyc rises the cycle after the request is sampled. Minimum request-to-slave latency is 1 cycle.
- BUSYn:
  - o_s_cyc=1; o_s_adr/dat/sel/we driven combinationally from master n.
  - o_mn_rdt = i_s_rdt, and o_mn_ack = i_s_ack (combinational, same cycle), both gated by grant.
  - On i_s_ack -> RELEASE.
  - If master n drops cyc before ack (abort) -> RELEASE, nothing forwarded.
- RELEASE: o_s_cyc=0 for exactly one cycle -> IDLE. Back-to-back transactions therefore occupy at least 1 (grant) + slave latency + 1 (release) cycles.
- Ungranted master: ack=0, rdt=0. Slave-side outputs are 0 when no master is granted.
- An i_s_ack arriving in IDLE or RELEASE (stray, e.g. after an abort) is discarded.
- A master's ack is never asserted unless that master's cyc is high in the same cycle.
- No priority inversion: after a grant to n, a waiting master m always receives the next grant.
- Reset mid-transaction: the bus drops immediately (o_s_cyc=0); no ack is delivered.

Optional Feature:
- Macro: ROCKETCPU_AUDIO_ARB_TIMEOUT_EN.
- Enabled:
  - The counter increments each cycle in BUSYn and clears on entry to BUSYn.
  - When it reaches TIMEOUT_CYCLES-1 without i_s_ack: assert o_mn_ack for one cycle with o_mn_rdt=32'h0, set o_timeout (sticky until reset), go to RELEASE.
  - If i_s_ack coincides with expiry, the slave ack wins and o_timeout is not set.
- Disabled: no counter logic; o_timeout tied 0; a hung slave blocks the bus indefinitely.

Decomposition:
- Shared package rocketcpu_audio_pkg holds:
  - state encoding constants (IDLE=2'd0, BUSY0=2'd1, BUSY1=2'd2, RELEASE=2'd3)
  - the audio register base 32'h1000_0000
  - the input-param base 32'h1001_0000
  - default TIMEOUT_CYCLES
- One natural sub-module: rocketcpu_rr_arbiter2, the 2-way round-robin pick plus last-grant register.
- The bus mux and FSM stay in the top module.

Test Plan:
- Single read: m0 reads 32'h1000_0004 with slave data 32'h0000_1234, slave acks 2 cycles after cyc -> o_m0_ack pulses once with o_m0_rdt=32'h0000_1234. Then o_s_cyc is low for exactly 1 cycle.
- Simultaneous requests: both cyc high from reset, m0 write 32'hAAAA_0001 to 32'h1000_0000, m1 write 32'hBBBB_0002 to 32'h1000_0008 -> m0 served first, then m1. The slave sees both writes in that order, and o_m1_ack never precedes o_m0_ack.
- Fairness: both masters hold cyc for 6 transactions each -> grants alternate 0,1,0,1,…; no master is granted twice in a row while the other waits.
- Abort: m1 drops cyc 1 cycle after grant, and the slave acks 1 cycle later -> no ack on either master; the FSM returns to IDLE via RELEASE; the next m0 request is served normally.
- Timeout (macro on, TIMEOUT_CYCLES=8): slave never acks an m0 read -> o_m0_ack asserted with rdt=0 at the 8th BUSY cycle, o_timeout=1 and held. Macro off: o_timeout stays 0.
- Async reset mid-BUSY1: i_rst_n pulsed low -> o_s_cyc=0 without waiting for a clock edge; after release the first tie is granted to m0.
